// File: rtl/axi_ddr_slave_model.sv
// AXI responder standing in for the DDR controller slave: fixed-length bursts into a 256-bit RAM.
// Write beats follow AWREADY back-to-back; read data follows ARREADY by RD_LATENCY; no backpressure on R.
module axi_ddr_slave_model #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DQ_WIDTH        = 32,
    parameter int BURST_LEN       = 8,
    parameter int MEM_AW          = 10,
    parameter int RD_LATENCY      = 4,
    parameter int INIT_CYCLES     = 16
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESET,
    output logic                       DDR_INIT_DONE,
    input  logic [3:0]                 S_AXI_AWID,
    input  logic [CTRL_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                       S_AXI_AWUSER,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [DQ_WIDTH*8-1:0]      S_AXI_WDATA,
    input  logic [DQ_WIDTH-1:0]        S_AXI_WSTRB,
    output logic                       S_AXI_WREADY,
    output logic                       S_AXI_WLAST,
    output logic [3:0]                 S_AXI_WUSER,
    input  logic [3:0]                 S_AXI_ARID,
    input  logic                       S_AXI_ARUSER,
    input  logic [CTRL_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [3:0]                 S_AXI_RID,
    output logic [DQ_WIDTH*8-1:0]      S_AXI_RDATA,
    output logic                       S_AXI_RVALID,
    output logic                       S_AXI_RLAST
);
    localparam int DW = DQ_WIDTH * 8;
    localparam int CW = $clog2(BURST_LEN + RD_LATENCY) + 1;
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LATENCY - 2);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_DATA} state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [IW-1:0]       r_init_cnt;
    logic                r_init_done;
    logic                r_last_wr;
    logic                r_awready, r_arready, r_wready, r_wlast, r_rvalid, r_rlast;
    logic [3:0]          r_rid;
    logic [DW-1:0]       r_rdata;
    logic [MEM_AW-1:0]   r_waddr, r_raddr;
    logic [DW-1:0]       r_mem [0:(1<<MEM_AW)-1];
    logic                w_acc_wr, w_acc_rd, w_wbeat, w_rbeat, w_last;
    logic                w_unused;

    assign w_unused = ^{S_AXI_AWID, S_AXI_AWUSER, S_AXI_ARUSER, S_AXI_AWADDR, S_AXI_ARADDR};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // With both requests pending, serve whichever type was not served last.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_wr    = 1'b0;
        w_acc_rd    = 1'b0;
        w_wbeat     = 1'b0;
        w_rbeat     = 1'b0;
        w_last      = (r_cnt == LAST_BEAT);
        case (r_state)
            IDLE: begin
                if (r_init_done) begin
                    if (S_AXI_AWVALID && (!S_AXI_ARVALID || !r_last_wr)) begin
                        w_acc_wr    = 1'b1;
                        w_state_nxt = WR_DATA;
                        w_cnt_nxt   = '0;
                    end else if (S_AXI_ARVALID) begin
                        w_acc_rd    = 1'b1;
                        w_state_nxt = RD_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            WR_DATA: begin
                w_wbeat   = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) w_state_nxt = IDLE;
            end
            RD_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state_nxt = RD_DATA;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RD_DATA: begin
                w_rbeat   = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_last_wr   <= 1'b0;
            r_awready   <= 1'b0;
            r_arready   <= 1'b0;
            r_wready    <= 1'b0;
            r_wlast     <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rid       <= '0;
            r_rdata     <= '0;
            r_waddr     <= '0;
            r_raddr     <= '0;
        end else begin
            if (!r_init_done) begin
                if (r_init_cnt == INIT_LAST) r_init_done <= 1'b1;
                else                         r_init_cnt  <= r_init_cnt + 1'b1;
            end
            r_awready <= w_acc_wr;
            r_arready <= w_acc_rd;
            r_wready  <= w_wbeat;
            r_wlast   <= w_wbeat && w_last;
            r_rvalid  <= w_rbeat;
            r_rlast   <= w_rbeat && w_last;
            if (w_acc_wr) begin
                r_waddr   <= S_AXI_AWADDR[MEM_AW+2:3];
                r_last_wr <= 1'b1;
            end else if (r_wready) begin
                r_waddr <= r_waddr + 1'b1;
            end
            if (w_acc_rd) begin
                r_raddr   <= S_AXI_ARADDR[MEM_AW+2:3];
                r_rid     <= S_AXI_ARID;
                r_last_wr <= 1'b0;
            end else if (w_rbeat) begin
                r_rdata <= r_mem[r_raddr];
                r_raddr <= r_raddr + 1'b1;
            end
        end
    end

    // The master drives the beat during the WREADY cycle; a reset in that cycle drops it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (r_wready && !S_AXI_ARESET) begin
            for (int b = 0; b < DQ_WIDTH; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[r_waddr][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    assign DDR_INIT_DONE = r_init_done;
    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_WLAST   = r_wlast;
    assign S_AXI_WUSER   = 4'b0;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
endmodule

// File: tb/tb_axi_ddr_slave_model.sv
// Bench for axi_ddr_slave_model: directed scenarios plus random traffic against a beat-array reference.
module tb_axi_ddr_slave_model;
    localparam int DW    = 256;
    localparam int NB    = 8;
    localparam int DEPTH = 1024;
    localparam int RDL   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          DDR_INIT_DONE;
    logic [3:0]    S_AXI_AWID = '0;
    logic [27:0]   S_AXI_AWADDR = '0;
    logic          S_AXI_AWUSER = 1'b0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA = '0;
    logic [31:0]   S_AXI_WSTRB = '0;
    logic          S_AXI_WREADY, S_AXI_WLAST;
    logic [3:0]    S_AXI_WUSER;
    logic [3:0]    S_AXI_ARID = '0;
    logic          S_AXI_ARUSER = 1'b0;
    logic [27:0]   S_AXI_ARADDR = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [3:0]    S_AXI_RID;
    logic [DW-1:0] S_AXI_RDATA;
    logic          S_AXI_RVALID, S_AXI_RLAST;

    axi_ddr_slave_model dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .DDR_INIT_DONE(DDR_INIT_DONE),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWUSER(S_AXI_AWUSER),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WUSER(S_AXI_WUSER),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARUSER(S_AXI_ARUSER), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RLAST(S_AXI_RLAST)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [270:0] all_outs = {DDR_INIT_DONE, S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_WLAST,
                             S_AXI_WUSER, S_AXI_RID, S_AXI_RVALID, S_AXI_RLAST, S_AXI_RDATA};

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic [3:0]    id;
        int            cyc;
    } rexp_t;

    rexp_t         rq[$];
    rexp_t         mon_e;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wd [NB];
    logic [31:0]   ws [NB];
    int            starts[$];
    bit            model_last_wr = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic int beat_idx(input int addr, input int n);
        return ((addr / 8) + n) % DEPTH;
    endfunction

    function automatic void ref_write(input int idx, input logic [DW-1:0] d, input logic [31:0] s);
        for (int b = 0; b < 32; b++)
            if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // Response monitor: every R beat is matched against the oldest expected beat.
    always @(negedge clk) begin
        if (S_AXI_AWREADY || S_AXI_ARREADY)
            check("ready_exclusive", 300'(S_AXI_AWREADY & S_AXI_ARREADY), 300'(0));
        if (S_AXI_RVALID) begin
            if (rq.size() == 0) begin
                fail("unexpected_rvalid");
            end else begin
                mon_e = rq.pop_front();
                check("rdata", 300'(S_AXI_RDATA), 300'(mon_e.d));
                check("rlast", 300'(S_AXI_RLAST), 300'(mon_e.last));
                check("rid", 300'(S_AXI_RID), 300'(mon_e.id));
                check("rvalid_cycle", 300'(cyc), 300'(mon_e.cyc));
            end
        end
    end

    task automatic wait_ready(input bit is_wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (is_wr ? S_AXI_AWREADY : S_AXI_ARREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail(is_wr ? "awready_timeout" : "arready_timeout");
    endtask

    task automatic wr_data_phase(input int aw_cyc, input int addr, input int reset_at);
        int k = 0;
        bit done = 1'b0;
        for (int i = 0; i < NB + 8 && !done; i++) begin
            @(negedge clk);
            if (S_AXI_WREADY) begin
                check("wready_cycle", 300'(cyc), 300'(aw_cyc + 1 + k));
                check("wlast", 300'(S_AXI_WLAST), 300'(k == NB - 1));
                S_AXI_WDATA = wd[k];
                S_AXI_WSTRB = ws[k];
                if (k == reset_at) begin
                    rst  = 1'b1;
                    done = 1'b1;
                end else begin
                    ref_write(beat_idx(addr, k), wd[k], ws[k]);
                    k++;
                    if (k == NB) done = 1'b1;
                end
            end
        end
        if (!done) fail("wready_timeout");
    endtask

    task automatic rd_accept(input int addr, input logic [3:0] id);
        rexp_t e;
        for (int n = 0; n < NB; n++) begin
            e.d    = ref_mem[beat_idx(addr, n)];
            e.last = (n == NB - 1);
            e.id   = id;
            e.cyc  = cyc + RDL + n;
            rq.push_back(e);
        end
        model_last_wr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && rq.size() != 0; i++) @(negedge clk);
        if (rq.size() != 0) begin
            fail("rvalid_timeout");
            rq.delete();
        end
    endtask

    task automatic do_write(input int addr, input int reset_at);
        bit ok;
        S_AXI_AWVALID = 1'b1;
        S_AXI_AWADDR  = addr[27:0];
        S_AXI_AWID    = 4'($urandom);
        wait_ready(1'b1, ok);
        S_AXI_AWVALID = 1'b0;
        if (ok) begin
            model_last_wr = 1'b1;
            wr_data_phase(cyc, addr, reset_at);
        end
    endtask

    task automatic do_read(input int addr, input logic [3:0] id);
        bit ok;
        S_AXI_ARVALID = 1'b1;
        S_AXI_ARADDR  = addr[27:0];
        S_AXI_ARID    = id;
        wait_ready(1'b0, ok);
        S_AXI_ARVALID = 1'b0;
        if (ok) begin
            rd_accept(addr, id);
            drain();
        end
    endtask

    task automatic do_both(input int waddr, input int raddr, input logic [3:0] id);
        bit ok = 1'b0;
        bit exp_wr = !model_last_wr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_AWADDR  = waddr[27:0];
        S_AXI_ARVALID = 1'b1;
        S_AXI_ARADDR  = raddr[27:0];
        S_AXI_ARID    = id;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (S_AXI_AWREADY || S_AXI_ARREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail("both_ready_timeout");
            S_AXI_AWVALID = 1'b0;
            S_AXI_ARVALID = 1'b0;
        end else if (S_AXI_AWREADY) begin
            check("rr_winner_is_write", 300'(1), 300'(exp_wr));
            S_AXI_AWVALID = 1'b0;
            model_last_wr = 1'b1;
            wr_data_phase(cyc, waddr, -1);
            wait_ready(1'b0, ok);
            S_AXI_ARVALID = 1'b0;
            if (ok) rd_accept(raddr, id);
            drain();
        end else begin
            check("rr_winner_is_write", 300'(0), 300'(exp_wr));
            S_AXI_ARVALID = 1'b0;
            rd_accept(raddr, id);
            wait_ready(1'b1, ok);
            S_AXI_AWVALID = 1'b0;
            if (ok) begin
                model_last_wr = 1'b1;
                wr_data_phase(cyc, waddr, -1);
            end
            drain();
        end
    endtask

    task automatic rand_data(input bit full_strb);
        for (int k = 0; k < NB; k++) begin
            wd[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ws[k] = full_strb ? 32'hFFFF_FFFF : $urandom;
        end
    endtask

    function automatic int pick_read_addr();
        int s = starts[$urandom_range(0, starts.size() - 1)];
        s = (s + $urandom_range(0, 15) * 8192) & 32'h0FFF_FFFF;
        return (s & ~7) | $urandom_range(0, 7);
    endfunction

    initial begin
        int a;
        for (int k = 0; k < NB; k++) begin
            wd[k] = {32{8'(k)}};
            ws[k] = 32'hFFFF_FFFF;
        end
        S_AXI_AWVALID = 1'b1;
        S_AXI_AWADDR  = 28'h40;
        repeat (3) @(negedge clk);
        check("reset_outputs", 300'(all_outs), 300'(0));
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            check("init_done", 300'(DDR_INIT_DONE), 300'(i >= 16));
            check("init_awready", 300'(S_AXI_AWREADY), 300'(i == 17));
        end
        S_AXI_AWVALID = 1'b0;
        if (S_AXI_AWREADY) begin
            model_last_wr = 1'b1;
            wr_data_phase(cyc, 'h40, -1);
        end
        starts.push_back('h40);
        do_read('h40, 4'h5);

        for (int k = 0; k < NB; k++) wd[k] = '1;
        do_write('h80, -1);
        for (int k = 0; k < NB; k++) begin
            wd[k] = '0;
            ws[k] = 32'h0000_000F;
        end
        do_write('h80, -1);
        starts.push_back('h80);
        do_read('h80, 4'h3);

        rand_data(1'b1);
        do_write(0, -1);
        rand_data(1'b1);
        do_write(1022 * 8, -1);
        starts.push_back(0);
        starts.push_back(1022 * 8);
        do_read(8192, 4'h7);
        do_read(1022 * 8, 4'h2);

        rand_data(1'b1);
        do_both('h300, 'h40, 4'h1);
        starts.push_back('h300);
        rand_data(1'b1);
        do_both('h380, 'h300, 4'h2);
        starts.push_back('h380);
        rand_data(1'b1);
        do_write('h400, -1);
        starts.push_back('h400);
        rand_data(1'b1);
        do_both('h480, 'h400, 4'h9);
        starts.push_back('h480);

        rand_data(1'b1);
        do_write('h200, -1);
        starts.push_back('h200);
        rand_data(1'b1);
        do_write('h200, 3);
        @(negedge clk);
        check("midburst_reset_outputs", 300'(all_outs), 300'(0));
        rst = 1'b0;
        model_last_wr = 1'b0;
        for (int i = 0; i < 40 && !DDR_INIT_DONE; i++) @(negedge clk);
        if (!DDR_INIT_DONE) fail("reinit_timeout");
        do_read('h200, 4'hC);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    if ($urandom_range(0, 1) == 1) begin
                        rand_data(1'b0);
                        do_write(pick_read_addr(), -1);
                    end else begin
                        rand_data(1'b1);
                        a = $urandom_range(0, 28'hFFF_FFFF);
                        do_write(a, -1);
                        starts.push_back(a);
                    end
                end
                1: do_read(pick_read_addr(), 4'($urandom));
                default: begin
                    rand_data(1'b1);
                    a = $urandom_range(0, 28'hFFF_FFFF);
                    do_both(a, pick_read_addr(), 4'($urandom));
                    starts.push_back(a);
                end
            endcase
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
